// File: rtl/mailbox_pkg.sv
// mailbox_pkg: arbiter FSM state type and requester-index width helper
package mailbox_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  function automatic int cpu_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mbox_rr_arbiter_rr_pick.sv
// mbox_rr_arbiter_rr_pick: rotating-priority encoder, scans ptr_i+1..ptr_i (mod N) over req_i; outputs valid_o and idx_o of first hit
module mbox_rr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 1; i <= N; i++) begin
      if (!valid_o && req_i[(int'(ptr_i) + i) % N]) begin
        valid_o = 1'b1;
        idx_o   = IW'((int'(ptr_i) + i) % N);
      end
    end
  end
endmodule

// File: rtl/mbox_rr_arbiter.sv
// mbox_rr_arbiter: round-robin share of one mailbox slave among N CPUs; in pclk_i/prst_i, req/addr/data/write_i per CPU, slv_ack/err/rdata_i; out gnt/ack/err_o per CPU, rdata_o, slv_req/addr/data/write/cpu_o, tmo_o; MBOX_ARB_TIMEOUT_EN enables slave-ack timeout
module mbox_rr_arbiter
  import mailbox_pkg::*;
#(
  parameter int N_NUMB_CPU  = 4,
  parameter int W_WIDTH_SYS = 32,
  parameter int WIDTH_ADDR  = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   pclk_i,
  input  logic                   prst_i,
  input  logic [N_NUMB_CPU-1:0]  req_i,
  input  logic [WIDTH_ADDR-1:0]  addr_i [N_NUMB_CPU],
  input  logic [W_WIDTH_SYS-1:0] data_i [N_NUMB_CPU],
  input  logic [N_NUMB_CPU-1:0]  write_i,
  output logic [N_NUMB_CPU-1:0]  gnt_o,
  output logic [N_NUMB_CPU-1:0]  ack_o,
  output logic [N_NUMB_CPU-1:0]  err_o,
  output logic [W_WIDTH_SYS-1:0] rdata_o,
  output logic                   slv_req_o,
  output logic [WIDTH_ADDR-1:0]  slv_addr_o,
  output logic [W_WIDTH_SYS-1:0] slv_data_o,
  output logic                   slv_write_o,
  output logic [31:0]            slv_cpu_o,
  input  logic                   slv_ack_i,
  input  logic                   slv_err_i,
  input  logic [W_WIDTH_SYS-1:0] slv_rdata_i,
  output logic                   tmo_o
);
  localparam int IW = cpu_idx_w(N_NUMB_CPU);
  arb_state_t             state_q;
  logic [IW-1:0]          ptr_q, idx_q, pick_idx;
  logic                   pick_valid, tmo_hit;
  logic [N_NUMB_CPU-1:0]  gnt_q, ack_q, err_q, pick_oh, own_oh;
  logic [W_WIDTH_SYS-1:0] rdata_q, data_q;
  logic [WIDTH_ADDR-1:0]  addr_q;
  logic                   slv_req_q, write_q, tmo_q;
  mbox_rr_arbiter_rr_pick #(.N(N_NUMB_CPU), .IW(IW)) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );
  assign pick_oh = N_NUMB_CPU'(1) << pick_idx;
  assign own_oh  = N_NUMB_CPU'(1) << idx_q;
`ifdef MBOX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt_q;
  assign tmo_hit = cnt_q == CW'(TIMEOUT_CYC - 1);
  // Zero outside BUSY, so it always starts from 0 on the first BUSY cycle
  always_ff @(posedge pclk_i) begin
    cnt_q <= (prst_i || state_q != BUSY) ? '0 : cnt_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(N_NUMB_CPU - 1);
      idx_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      slv_req_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: if (pick_valid) begin
          idx_q     <= pick_idx;
          addr_q    <= addr_i[pick_idx];
          data_q    <= data_i[pick_idx];
          write_q   <= write_i[pick_idx];
          gnt_q     <= pick_oh;
          slv_req_q <= 1'b1;
          state_q   <= BUSY;
        end
        // A real slave ack in the same cycle takes precedence over the timeout
        BUSY: if (slv_ack_i || tmo_hit) begin
          ack_q     <= own_oh;
          err_q     <= (!slv_ack_i || slv_err_i) ? own_oh : '0;
          rdata_q   <= slv_ack_i ? slv_rdata_i : '0;
          tmo_q     <= !slv_ack_i;
          slv_req_q <= 1'b0;
          gnt_q     <= '0;
          ptr_q     <= idx_q;
          state_q   <= RESP;
        end
        // One dead cycle so the owner's still-high req is not re-arbitrated
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt_o       = gnt_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign slv_req_o   = slv_req_q;
  assign slv_addr_o  = addr_q;
  assign slv_data_o  = data_q;
  assign slv_write_o = write_q;
  assign slv_cpu_o   = 32'(idx_q);
  assign tmo_o       = tmo_q;
endmodule

// File: tb/tb_mbox_rr_arbiter.sv
// tb_mbox_rr_arbiter: directed self-checking bench for mbox_rr_arbiter (N=4, TIMEOUT_CYC=8)
module tb_mbox_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, write, gnt, ack, err;
  logic [31:0] addr [4];
  logic [31:0] data [4];
  logic [31:0] rdata, slv_addr, slv_data, slv_cpu, slv_rdata;
  logic        slv_req, slv_write, slv_ack, slv_err, tmo;
  int          errors = 0;
  int          checks = 0;
`ifdef MBOX_ARB_TIMEOUT_EN
  localparam int STALL = 6;
`else
  localparam int STALL = 10;
`endif
  always #5 clk = ~clk;
  mbox_rr_arbiter #(.N_NUMB_CPU(4), .W_WIDTH_SYS(32), .WIDTH_ADDR(32), .TIMEOUT_CYC(8)) dut (
    .pclk_i      (clk),
    .prst_i      (rst),
    .req_i       (req),
    .addr_i      (addr),
    .data_i      (data),
    .write_i     (write),
    .gnt_o       (gnt),
    .ack_o       (ack),
    .err_o       (err),
    .rdata_o     (rdata),
    .slv_req_o   (slv_req),
    .slv_addr_o  (slv_addr),
    .slv_data_o  (slv_data),
    .slv_write_o (slv_write),
    .slv_cpu_o   (slv_cpu),
    .slv_ack_i   (slv_ack),
    .slv_err_i   (slv_err),
    .slv_rdata_i (slv_rdata),
    .tmo_o       (tmo)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, ".gnt"}, gnt, 0);
    chk({tag, ".ack"}, ack, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".rdata"}, rdata, 0);
    chk({tag, ".slv_req"}, slv_req, 0);
    chk({tag, ".slv_addr"}, slv_addr, 0);
    chk({tag, ".slv_data"}, slv_data, 0);
    chk({tag, ".slv_write"}, slv_write, 0);
    chk({tag, ".slv_cpu"}, slv_cpu, 0);
    chk({tag, ".tmo"}, tmo, 0);
  endtask
  initial begin
    rst = 1'b1; req = '0; write = '0; slv_ack = 1'b0; slv_err = 1'b0; slv_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      addr[i] = '0;
      data[i] = '0;
    end
    tick(); tick();
    chk_idle("reset");
    rst = 1'b0;
    req[2] = 1'b1; write[2] = 1'b1; addr[2] = 32'h10; data[2] = 32'hA5;
    tick();
    chk("single.slv_req", slv_req, 1);
    chk("single.slv_cpu", slv_cpu, 2);
    chk("single.gnt", gnt, 4'b0100);
    chk("single.fields", {slv_addr, slv_data}, {32'h10, 32'hA5});
    chk("single.write", slv_write, 1);
    slv_ack = 1'b1;
    tick();
    chk("single.ack", ack, 4'b0100);
    chk("single.err", err, 0);
    chk("single.released", {slv_req, gnt}, 0);
    slv_ack = 1'b0; req = '0;
    tick();
    chk("single.ack_pulse", ack, 0);
    slv_ack = 1'b1;
    tick();
    chk("stray_ack.ack", ack, 0);
    slv_ack = 1'b0;
    tick();
    chk("stray_ack.idle", {slv_req, gnt, ack}, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'hF; write = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fair.cpu", slv_cpu, k % 4);
      chk("fair.gnt", gnt, 1 << (k % 4));
      slv_ack = 1'b1;
      tick();
      chk("fair.ack", ack, 1 << (k % 4));
      slv_ack = 1'b0;
      tick();
    end
    req = 4'b0010; write[1] = 1'b0; addr[1] = 32'h20;
    tick();
    chk("read.cpu", slv_cpu, 1);
    chk("read.write", slv_write, 0);
    chk("read.addr", slv_addr, 32'h20);
    slv_ack = 1'b1; slv_err = 1'b1; slv_rdata = 32'hDEADBEEF;
    tick();
    chk("read.ack", ack, 4'b0010);
    chk("read.err", err, 4'b0010);
    chk("read.rdata", rdata, 32'hDEADBEEF);
    slv_ack = 1'b0; slv_err = 1'b0; slv_rdata = '0; req = '0;
    tick();
    chk("read.rdata_hold", rdata, 32'hDEADBEEF);
    chk("read.err_clear", err, 0);
    req[3] = 1'b1; write[3] = 1'b1; addr[3] = 32'h30; data[3] = 32'h33;
    tick();
    chk("stab.grant", {slv_cpu[3:0], gnt}, {4'd3, 4'b1000});
    for (int k = 0; k < STALL; k++) begin
      req[2:0] = 3'(k + 1);
      addr[3] = k;
      data[3] = ~k;
      write[3] = k[0];
      if (k == 2) req[3] = 1'b0;
      tick();
      chk("stab.fields", {slv_addr, slv_data}, {32'h30, 32'h33});
      chk("stab.ctl", {slv_write, slv_cpu[3:0], gnt, slv_req, ack}, {1'b1, 4'd3, 4'b1000, 1'b1, 4'b0});
    end
    req = '0; slv_ack = 1'b1; slv_rdata = 32'h12345678;
    tick();
    chk("stab.ack_after_drop", ack, 4'b1000);
    slv_ack = 1'b0;
    tick();
    req = 4'b0001;
    tick();
    chk("cpu0.cpu", slv_cpu, 0);
    slv_ack = 1'b1; req = '0;
    tick();
    slv_ack = 1'b0;
    tick();
    req = 4'b0100;
    tick();
    chk("midrst.busy", {slv_req, slv_cpu[3:0]}, {1'b1, 4'd2});
    rst = 1'b1;
    tick();
    chk_idle("midrst");
    rst = 1'b0; req = 4'b0011;
    tick();
    chk("midrst.cpu0_first", {slv_cpu[3:0], gnt}, {4'd0, 4'b0001});
    slv_ack = 1'b1; req = '0;
    tick();
    chk("midrst.ack", ack, 4'b0001);
    slv_ack = 1'b0;
    tick();
    req = 4'b0010; write[1] = 1'b1;
    tick();
    chk("tmo.cpu", slv_cpu, 1);
    req = '0;
    for (int k = 0; k < 7; k++) tick();
    chk("tmo.pre", {ack, tmo, slv_req}, {4'b0, 1'b0, 1'b1});
    tick();
`ifdef MBOX_ARB_TIMEOUT_EN
    chk("tmo.ack", ack, 4'b0010);
    chk("tmo.err", err, 4'b0010);
    chk("tmo.pulse", tmo, 1);
    chk("tmo.rdata", rdata, 0);
    chk("tmo.released", {slv_req, gnt}, 0);
    tick();
    chk("tmo.pulse_end", {tmo, ack}, 0);
`else
    chk("notmo.busy", {ack, tmo, slv_req, gnt}, {4'b0, 1'b0, 1'b1, 4'b0010});
    for (int k = 0; k < 4; k++) tick();
    chk("notmo.still_busy", {ack, tmo, slv_req}, {4'b0, 1'b0, 1'b1});
    slv_ack = 1'b1;
    tick();
    chk("notmo.ack", ack, 4'b0010);
    chk("notmo.rdata", rdata, 32'h12345678);
    slv_ack = 1'b0;
    tick();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
